// File: rtl/siw_memory_bram_param.sv
// siw_memory_bram_param
//   One memory bank for the SideWorks datapath. It has two ports on one clock.
//   Each port's write enable can be delayed by 0..MAX_DLY cycles so that it
//   lines up with the datapath latency. The address and data are always used
//   undelayed. Reads are read-first and have a 2-cycle latency: one cycle for
//   the array and one for the output register. A valid flag follows each read.
//   When both ports write the same address in one cycle, port A wins and a
//   sticky collision flag is raised.
//
// Ports
//   siw_memory_bram_0_clk_a   single clock for memory and all registers
//   siw_memory_bram_0_reset   asynchronous active-high reset (array not cleared)
//   init                      synchronous clear of delay lines and collision
//   mem_sel                   host access, qualifies port-A writes like enable_a
//   enable_x / write_en_x     access enable / raw (undelayed) write request
//   address_x / input_data_x  current-cycle address and write data
//   mem_conf_x                write-enable delay tap (0 = undelayed)
//   output_data_x             registered read data, holds between reads
//   output_valid_x            high exactly 2 cycles after a read strobe
//   collision                 sticky same-address dual-write flag
module siw_memory_bram_param #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 10,
  parameter int MAX_DLY = 3,
  parameter int CONF_W  = 2
) (
  input  logic              siw_memory_bram_0_clk_a,
  input  logic              siw_memory_bram_0_reset,
  input  logic              init,
  input  logic              mem_sel,
  input  logic              enable_a,
  input  logic              write_en_a,
  input  logic [ADDR_W-1:0] address_a,
  input  logic [DATA_W-1:0] input_data_a,
  input  logic [CONF_W-1:0] mem_conf_a,
  output logic [DATA_W-1:0] output_data_a,
  output logic              output_valid_a,
  input  logic              enable_b,
  input  logic              write_en_b,
  input  logic [ADDR_W-1:0] address_b,
  input  logic [DATA_W-1:0] input_data_b,
  input  logic [CONF_W-1:0] mem_conf_b,
  output logic [DATA_W-1:0] output_data_b,
  output logic              output_valid_b,
  output logic              collision
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [MAX_DLY:1]  wd_a, wd_b;
  logic              wsel_a, wsel_b;
  logic              we_a, we_b, rd_a, rd_b, same_addr;
  logic [DATA_W-1:0] mem_q_a, mem_q_b;
  logic              v1_a, v1_b;

  // Tap 0 bypasses the delay line. Taps above MAX_DLY saturate to the last stage.
  function automatic logic sel_tap(input logic [MAX_DLY:1] wd,
                                   input logic             we,
                                   input logic [CONF_W-1:0] conf);
    logic s;
    s = we;
    if (conf != '0) begin
      s = wd[MAX_DLY];
      for (int k = 1; k < MAX_DLY; k++)
        if (int'(conf) == k) s = wd[k];
    end
    return s;
  endfunction

  always_comb begin
    wsel_a    = sel_tap(wd_a, write_en_a, mem_conf_a);
    wsel_b    = sel_tap(wd_b, write_en_b, mem_conf_b);
    we_a      = wsel_a & (enable_a | mem_sel);
    we_b      = wsel_b & enable_b;
    rd_a      = enable_a & ~we_a;
    rd_b      = enable_b & ~we_b;
    same_addr = (address_a == address_b);
  end

  // Write-enable delay lines. A new request is shifted into stage 1.
  // init clears every stage, which also drops a request arriving in that cycle.
  always_ff @(posedge siw_memory_bram_0_clk_a or posedge siw_memory_bram_0_reset) begin
    if (siw_memory_bram_0_reset) begin
      wd_a <= '0;
      wd_b <= '0;
    end else if (init) begin
      wd_a <= '0;
      wd_b <= '0;
    end else begin
      wd_a <= MAX_DLY'({wd_a, write_en_a});
      wd_b <= MAX_DLY'({wd_b, write_en_b});
    end
  end

  // Array and read register. This block has no reset so that it maps onto
  // block RAM. Non-blocking reads give read-first behaviour. On a
  // same-address collision, port B's write is suppressed so that A's data lands.
  always_ff @(posedge siw_memory_bram_0_clk_a) begin
    if (we_a) mem[address_a] <= input_data_a;
    if (we_b && !(we_a && same_addr)) mem[address_b] <= input_data_b;
    if (rd_a) mem_q_a <= mem[address_a];
    if (rd_b) mem_q_b <= mem[address_b];
  end

  // Output stage, valid tracking and the sticky collision flag.
  always_ff @(posedge siw_memory_bram_0_clk_a or posedge siw_memory_bram_0_reset) begin
    if (siw_memory_bram_0_reset) begin
      v1_a           <= 1'b0;
      v1_b           <= 1'b0;
      output_valid_a <= 1'b0;
      output_valid_b <= 1'b0;
      output_data_a  <= '0;
      output_data_b  <= '0;
      collision      <= 1'b0;
    end else begin
      v1_a           <= rd_a;
      v1_b           <= rd_b;
      output_valid_a <= v1_a;
      output_valid_b <= v1_b;
      if (v1_a) output_data_a <= mem_q_a;
      if (v1_b) output_data_b <= mem_q_b;
      if (init)
        collision <= 1'b0;
      else if (we_a && we_b && same_addr)
        collision <= 1'b1;
    end
  end

endmodule

// File: tb/tb_siw_memory_bram_param.sv
// tb_siw_memory_bram_param
//   Bench for siw_memory_bram_param. It uses the default parameters: 32-bit
//   data, 10-bit address and 3 delay stages. Expected read data is queued
//   when a read is issued and popped when the matching valid appears.
//   Inputs are driven on the falling edge and outputs are sampled there too.
module tb_siw_memory_bram_param;

  logic        siw_memory_bram_0_clk_a = 1'b0;
  logic        siw_memory_bram_0_reset;
  logic        init, mem_sel;
  logic        enable_a, write_en_a, enable_b, write_en_b;
  logic [9:0]  address_a, address_b;
  logic [31:0] input_data_a, input_data_b;
  logic [1:0]  mem_conf_a, mem_conf_b;
  logic [31:0] output_data_a, output_data_b;
  logic        output_valid_a, output_valid_b, collision;

  int n_compared   = 0;
  int n_mismatched = 0;

  logic [31:0] exp_a[$];
  logic [31:0] exp_b[$];

  siw_memory_bram_param dut (
    .siw_memory_bram_0_clk_a (siw_memory_bram_0_clk_a),
    .siw_memory_bram_0_reset (siw_memory_bram_0_reset),
    .init           (init),
    .mem_sel        (mem_sel),
    .enable_a       (enable_a),
    .write_en_a     (write_en_a),
    .address_a      (address_a),
    .input_data_a   (input_data_a),
    .mem_conf_a     (mem_conf_a),
    .output_data_a  (output_data_a),
    .output_valid_a (output_valid_a),
    .enable_b       (enable_b),
    .write_en_b     (write_en_b),
    .address_b      (address_b),
    .input_data_b   (input_data_b),
    .mem_conf_b     (mem_conf_b),
    .output_data_b  (output_data_b),
    .output_valid_b (output_valid_b),
    .collision      (collision)
  );

  always #5 siw_memory_bram_0_clk_a = ~siw_memory_bram_0_clk_a;

  task automatic step();
    @(negedge siw_memory_bram_0_clk_a);
  endtask

  task automatic idle();
    init = 0; mem_sel = 0;
    enable_a = 0; write_en_a = 0; enable_b = 0; write_en_b = 0;
  endtask

  task automatic write_a(input logic [9:0] addr, input logic [31:0] data);
    mem_conf_a = 0; enable_a = 1; write_en_a = 1; address_a = addr; input_data_a = data;
    step(); idle();
  endtask

  task automatic read_b(input logic [9:0] addr, input logic [31:0] e);
    enable_b = 1; write_en_b = 0; address_b = addr; exp_b.push_back(e);
    step(); enable_b = 0;
  endtask

  // Bounded wait for port B valid; reports latency in cycles from the read cycle.
  task automatic wait_valid_b(output bit got, output logic [31:0] d, output int lat);
    got = 0; d = '0; lat = 0;
    for (int i = 0; i < 6; i++) begin
      if (!got) begin
        if (output_valid_b) begin got = 1; d = output_data_b; lat = i + 1; end
        else step();
      end
    end
  endtask

  task automatic test_reset();
    siw_memory_bram_0_reset = 1; idle();
    step(); step();
    n_compared++; if (output_data_a !== 32'h0) begin n_mismatched++; $display("[TB] FAIL reset_data_a: got %h expected 0", output_data_a); end
    n_compared++; if (output_data_b !== 32'h0) begin n_mismatched++; $display("[TB] FAIL reset_data_b: got %h expected 0", output_data_b); end
    n_compared++; if (output_valid_a !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_valid_a: got %b expected 0", output_valid_a); end
    n_compared++; if (output_valid_b !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_valid_b: got %b expected 0", output_valid_b); end
    n_compared++; if (collision !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_collision: got %b expected 0", collision); end
    siw_memory_bram_0_reset = 0;
    step();
  endtask

  task automatic test_basic_write_read();
    bit got; logic [31:0] d, e; int lat;
    write_a(10'd5, 32'hDEADBEEF);
    read_b(10'd5, 32'hDEADBEEF);
    wait_valid_b(got, d, lat);
    e = exp_b.pop_front();
    n_compared++; if (!got || d !== e) begin n_mismatched++; $display("[TB] FAIL basic_data: got %h (valid %b) expected %h", d, got, e); end
    n_compared++; if (lat !== 2) begin n_mismatched++; $display("[TB] FAIL basic_latency: got %0d expected 2", lat); end
    step();
    n_compared++; if (output_valid_b !== 1'b0) begin n_mismatched++; $display("[TB] FAIL basic_valid_pulse: got %b expected 0", output_valid_b); end
    n_compared++; if (output_data_b !== 32'hDEADBEEF) begin n_mismatched++; $display("[TB] FAIL basic_data_hold: got %h expected deadbeef", output_data_b); end
  endtask

  task automatic test_delayed_write();
    bit got; logic [31:0] d, e; int lat;
    write_a(10'd8, 32'h22);
    // conf 2: the request at cycle 0 writes with the address/data of cycle 2
    mem_conf_a = 2;
    write_en_a = 1; step();
    write_en_a = 0; step();
    enable_a = 1; address_a = 10'd7; input_data_a = 32'h11; step();
    idle();
    // The same request with no enable at the tap cycle must not write
    write_en_a = 1; step();
    write_en_a = 0; step();
    address_a = 10'd8; input_data_a = 32'hFF; step();
    // conf 1 write qualified only by mem_sel
    mem_conf_a = 1;
    write_en_a = 1; step();
    write_en_a = 0; mem_sel = 1; address_a = 10'd12; input_data_a = 32'h33; step();
    idle(); mem_conf_a = 0;
    read_b(10'd7, 32'h11);
    wait_valid_b(got, d, lat); e = exp_b.pop_front();
    n_compared++; if (!got || d !== e) begin n_mismatched++; $display("[TB] FAIL delayed_write: got %h (valid %b) expected %h", d, got, e); end
    read_b(10'd8, 32'h22);
    wait_valid_b(got, d, lat); e = exp_b.pop_front();
    n_compared++; if (!got || d !== e) begin n_mismatched++; $display("[TB] FAIL delayed_no_enable: got %h (valid %b) expected %h", d, got, e); end
    read_b(10'd12, 32'h33);
    wait_valid_b(got, d, lat); e = exp_b.pop_front();
    n_compared++; if (!got || d !== e) begin n_mismatched++; $display("[TB] FAIL mem_sel_write: got %h (valid %b) expected %h", d, got, e); end
  endtask

  task automatic test_collision();
    bit got; logic [31:0] d, e; int lat;
    mem_conf_a = 0; mem_conf_b = 0;
    enable_a = 1; write_en_a = 1; address_a = 10'd3; input_data_a = 32'hAAAA;
    enable_b = 1; write_en_b = 1; address_b = 10'd3; input_data_b = 32'h5555;
    step(); idle();
    n_compared++; if (collision !== 1'b1) begin n_mismatched++; $display("[TB] FAIL collision_set: got %b expected 1", collision); end
    read_b(10'd3, 32'hAAAA);
    wait_valid_b(got, d, lat); e = exp_b.pop_front();
    n_compared++; if (!got || d !== e) begin n_mismatched++; $display("[TB] FAIL collision_data: got %h (valid %b) expected %h", d, got, e); end
    enable_a = 1; write_en_a = 1; address_a = 10'd20; input_data_a = 32'h2020;
    enable_b = 1; write_en_b = 1; address_b = 10'd21; input_data_b = 32'h2121;
    step(); idle();
    read_b(10'd20, 32'h2020);
    wait_valid_b(got, d, lat); e = exp_b.pop_front();
    n_compared++; if (!got || d !== e) begin n_mismatched++; $display("[TB] FAIL dual_write_a: got %h (valid %b) expected %h", d, got, e); end
    read_b(10'd21, 32'h2121);
    wait_valid_b(got, d, lat); e = exp_b.pop_front();
    n_compared++; if (!got || d !== e) begin n_mismatched++; $display("[TB] FAIL dual_write_b: got %h (valid %b) expected %h", d, got, e); end
    n_compared++; if (collision !== 1'b1) begin n_mismatched++; $display("[TB] FAIL collision_sticky: got %b expected 1", collision); end
    init = 1; step(); init = 0;
    n_compared++; if (collision !== 1'b0) begin n_mismatched++; $display("[TB] FAIL collision_init_clear: got %b expected 0", collision); end
  endtask

  task automatic test_init_cancel();
    bit got; logic [31:0] d, e; int lat;
    mem_conf_b = 0;
    enable_b = 1; write_en_b = 1; address_b = 10'd4; input_data_b = 32'h44;
    step(); idle();
    mem_conf_b = 3;
    write_en_b = 1; step();
    write_en_b = 0; init = 1; step();
    init = 0; step();
    // Tap cycle: a surviving request would write here instead of reading
    enable_b = 1; address_b = 10'd4; input_data_b = 32'h99; exp_b.push_back(32'h44);
    step(); enable_b = 0;
    wait_valid_b(got, d, lat); e = exp_b.pop_front();
    n_compared++; if (!got || d !== e) begin n_mismatched++; $display("[TB] FAIL init_cancel_tap: got %h (valid %b) expected %h", d, got, e); end
    mem_conf_b = 0;
    read_b(10'd4, 32'h44);
    wait_valid_b(got, d, lat); e = exp_b.pop_front();
    n_compared++; if (!got || d !== e) begin n_mismatched++; $display("[TB] FAIL init_cancel_mem: got %h (valid %b) expected %h", d, got, e); end
  endtask

  task automatic test_read_during_write();
    bit got; logic [31:0] d, e; int lat;
    write_a(10'd9, 32'h1);
    enable_a = 1; write_en_a = 1; address_a = 10'd9; input_data_a = 32'h2;
    enable_b = 1; write_en_b = 0; address_b = 10'd9; exp_b.push_back(32'h1);
    step(); idle();
    wait_valid_b(got, d, lat); e = exp_b.pop_front();
    n_compared++; if (!got || d !== e) begin n_mismatched++; $display("[TB] FAIL rdw_old_data: got %h (valid %b) expected %h", d, got, e); end
    read_b(10'd9, 32'h2);
    wait_valid_b(got, d, lat); e = exp_b.pop_front();
    n_compared++; if (!got || d !== e) begin n_mismatched++; $display("[TB] FAIL rdw_new_data: got %h (valid %b) expected %h", d, got, e); end
  endtask

  task automatic test_back_to_back();
    logic [9:0]  addrs [4] = '{10'd5, 10'd7, 10'd3, 10'd9};
    logic [31:0] exps  [4] = '{32'hDEADBEEF, 32'h11, 32'hAAAA, 32'h2};
    logic [31:0] e;
    int seen = 0;
    mem_conf_a = 0;
    for (int c = 0; c < 10; c++) begin
      if (c < 4) begin
        enable_a = 1; write_en_a = 0; address_a = addrs[c]; exp_a.push_back(exps[c]);
      end else begin
        enable_a = 0;
      end
      step();
      if (output_valid_a) begin
        seen++;
        e = (exp_a.size() > 0) ? exp_a.pop_front() : 32'hX;
        n_compared++; if (output_data_a !== e) begin n_mismatched++; $display("[TB] FAIL b2b_data: got %h expected %h", output_data_a, e); end
      end
    end
    n_compared++; if (seen !== 4) begin n_mismatched++; $display("[TB] FAIL b2b_count: got %0d expected 4", seen); end
  endtask

  task automatic test_reset_midpipe();
    bit got; logic [31:0] d, e; int lat;
    enable_a = 1; write_en_a = 1; address_a = 10'd40; input_data_a = 32'h1;
    enable_b = 1; write_en_b = 1; address_b = 10'd40; input_data_b = 32'h2;
    step(); idle();
    // Load the delay line and both stage-1 valids
    mem_conf_a = 3;
    enable_a = 1; write_en_a = 1; address_a = 10'd5;
    enable_b = 1; write_en_b = 0; address_b = 10'd5;
    step(); idle();
    #1 siw_memory_bram_0_reset = 1;
    #1;
    n_compared++; if (output_data_a !== 32'h0) begin n_mismatched++; $display("[TB] FAIL midreset_data_a: got %h expected 0", output_data_a); end
    n_compared++; if (output_data_b !== 32'h0) begin n_mismatched++; $display("[TB] FAIL midreset_data_b: got %h expected 0", output_data_b); end
    n_compared++; if (collision !== 1'b0) begin n_mismatched++; $display("[TB] FAIL midreset_collision: got %b expected 0", collision); end
    step();
    siw_memory_bram_0_reset = 0;
    // Anything left in the delay line would overwrite address 5 now
    mem_sel = 1; address_a = 10'd5; input_data_a = 32'hBAD;
    step();
    n_compared++; if (output_valid_a !== 1'b0 || output_valid_b !== 1'b0) begin n_mismatched++; $display("[TB] FAIL midreset_valids: got %b%b expected 00", output_valid_a, output_valid_b); end
    repeat (4) step();
    idle(); mem_conf_a = 0;
    read_b(10'd5, 32'hDEADBEEF);
    wait_valid_b(got, d, lat); e = exp_b.pop_front();
    n_compared++; if (!got || d !== e) begin n_mismatched++; $display("[TB] FAIL midreset_preserved: got %h (valid %b) expected %h", d, got, e); end
  endtask

  initial begin
    siw_memory_bram_0_reset = 1;
    idle();
    mem_conf_a = 0; mem_conf_b = 0;
    address_a = 0; address_b = 0; input_data_a = 0; input_data_b = 0;
    test_reset();
    test_basic_write_read();
    test_delayed_write();
    test_collision();
    test_init_cancel();
    test_read_during_write();
    test_back_to_back();
    test_reset_midpipe();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/siw_memory_bram_param.md
Name: siw_memory_bram_param

Overview:
Parametrised successor of the fixed 1024x32 dual-port BRAM wrapper. Both ports run on one clock. Each port has a programmable write-enable alignment delay of 0..MAX_DLY cycles. The block adds registered read-valid tracking, a same-address write-collision policy with a sticky flag, and an inferred memory array of configurable width and depth. It sits between the SideWorks datapath/address generators and on-chip RAM and is instantiated once per memory bank.

Parameters:
DATA_W, 32, data width in bits (1..64)
ADDR_W, 10, address width; depth = 2**ADDR_W words
MAX_DLY, 3, maximum write-enable delay in cycles (1..7)
CONF_W, 2, width of the mem_conf ports; must satisfy 2**CONF_W >= MAX_DLY+1

Ports:
siw_memory_bram_0_clk_a  in  1  single clock for both ports, memory and all registers
siw_memory_bram_0_reset  in  1  asynchronous, active-high reset
init  in  1  synchronous clear of the delay lines and the collision flag
mem_sel  in  1  host/configuration access; qualifies port-A writes like enable_a
enable_a  in  1  port A access enable
write_en_a  in  1  port A raw write request (before delay)
address_a  in  ADDR_W  port A address (used undelayed)
input_data_a  in  DATA_W  port A write data (used undelayed)
mem_conf_a  in  CONF_W  port A write-enable delay select
output_data_a  out  DATA_W  port A registered read data
output_valid_a  out  1  port A read data valid
enable_b, write_en_b, address_b, input_data_b, mem_conf_b  in  as port A  port B equivalents; no mem_sel term
output_data_b  out  DATA_W  port B registered read data
output_valid_b  out  1  port B read data valid
collision  out  1  sticky flag: both ports wrote the same address in one cycle

Behaviour:
- Reset (async): delay lines, output_data_a/b, output_valid_a/b and collision are all cleared to 0. Memory contents are not cleared.
- Delay line per port: wd[1..MAX_DLY], with wd[1] <= write_en and wd[k] <= wd[k-1]. When init=1, every stage loads 0 on the next edge.
- Selected write enable: wsel = write_en when conf=0, otherwise wd[conf]. If conf > MAX_DLY, wsel = wd[MAX_DLY] (saturates).
- Effective writes:
  - weA = wsel_a & (enable_a | mem_sel)
  - weB = wsel_b & enable_b
- The write uses the current-cycle address and data. Only the enable is delayed, which matches the datapath latency.
- Read strobe: rdX = enable_X & ~weX. The memory read is read-first and takes 1 cycle. The output register adds 1 more cycle, so read latency is 2 cycles from the address.
- output_valid_X is high exactly 2 cycles after an rdX cycle. output_data_X updates only on cycles where stage-1 valid is set; otherwise it holds its value.
- Read-during-write on the same address, same or opposite port: the read returns the old data.
- Collision: if weA & weB & (address_a == address_b), port A's data is written and collision is set on the next edge. collision stays set until init or reset. If the addresses differ, both writes complete.
- If init and a new write request arrive in the same cycle, init wins: no delayed write results from that request. A conf=0 write in the same cycle still occurs, because it is undelayed.
- Reset mid-pipeline: pending delayed writes and in-flight valids are discarded. A read after reset returns the preserved memory contents.
- Changing mem_conf takes effect combinationally. Requests already in the delay line are selected by the new tap.

Test Plan:
- conf_a=0, write 0xDEADBEEF to addr 5; read addr 5 on port B -> output_data_b=0xDEADBEEF and output_valid_b=1 exactly 2 cycles after the read cycle.
- conf_a=2, pulse write_en_a at cycle 0 with enable_a=1 and addr=7 presented at cycle 2, data 0x11 -> addr 7 holds 0x11; addr 7 is unchanged if enable_a=0 at cycle 2 and mem_sel=0.
- Both ports write addr 3 in the same cycle (A=0xAAAA, B=0x5555) -> memory holds 0xAAAA, collision=1 and stays 1; after an init pulse, collision=0.
- conf_b=3 write pending, init asserted at cycle 1 -> no write occurs at cycle 3; memory is unchanged.
- Read and write on addr 9 in the same cycle (old value 0x1, new value 0x2) -> read returns 0x1; the next read returns 0x2.
- Assert reset with delay stages and valid stages loaded -> all outputs are 0 immediately; earlier memory contents still read back correctly after reset is released.
